// File: rtl/hpi_pkg.sv
// Shared HPI target definitions: register map, STATUS layout
// and the registered strobe bundle.
package hpi_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_MBX  = 2'd1;
  localparam logic [1:0] REG_ADDR = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam int ST_IN_VLD   = 0;
  localparam int ST_OUT_FULL = 1;
  localparam int ST_IN_OVR   = 2;
  localparam int ST_OUT_OVR  = 3;

  typedef struct packed {
    logic        cs_n;
    logic        r_n;
    logic        w_n;
    logic [1:0]  addr;
    logic [15:0] data;
  } hpi_bus_t;

  // Strobes reset low so one held low across reset release is no edge
  localparam hpi_bus_t BUS_IDLE = '{
    cs_n: 1'b1, r_n: 1'b0, w_n: 1'b0, addr: 2'd0, data: 16'd0
  };

  function automatic logic [15:0] stat_word(
    input logic in_vld,
    input logic out_full,
    input logic in_ovr,
    input logic out_ovr
  );
    logic [15:0] s;
    s = '0;
    s[ST_IN_VLD]   = in_vld;
    s[ST_OUT_FULL] = out_full;
    s[ST_IN_OVR]   = in_ovr;
    s[ST_OUT_OVR]  = out_ovr;
    return s;
  endfunction

endpackage

// File: rtl/hpi_dpram.sv
// True dual-port 16-bit sync-read RAM, read-before-write.
// Port A (host) wins a same-word write collision.
module hpi_dpram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [15:0]   a_wdata,
  output logic [15:0]   a_rdata,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [15:0]   b_wdata,
  output logic [15:0]   b_rdata
);

  logic [15:0] mem [2**AW];
  logic [15:0] a_rdata_q;
  logic [15:0] b_rdata_q;

  // Port A is written last so its data survives a collision
  always_ff @(posedge clk) begin
    if (b_we) mem[b_addr] <= b_wdata;
    if (a_we) mem[a_addr] <= a_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= mem[a_addr];
      b_rdata_q <= mem[b_addr];
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/hpi_target.sv
// HPI responder: strobe edge detect, register decode, address
// pointer, two mailboxes and the read-data pipe.
module hpi_target
  import hpi_pkg::*;
#(
  parameter int MEM_AW = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [1:0]        hpi_address,
  input  logic              hpi_cs_n,
  input  logic              hpi_r_n,
  input  logic              hpi_w_n,
  input  logic [15:0]       hpi_data_in,
  output logic [15:0]       hpi_data_out,
  output logic              hpi_int,
  input  logic [MEM_AW-1:0] loc_addr,
  input  logic              loc_we,
  input  logic [15:0]       loc_wdata,
  output logic [15:0]       loc_rdata,
  output logic [15:0]       mbx_in_data,
  output logic              mbx_in_valid,
  input  logic              mbx_in_ack,
  input  logic [15:0]       mbx_out_data,
  input  logic              mbx_out_wr,
  output logic              mbx_out_full
);

  localparam int DEPTH = RD_LAT - 1;

  hpi_bus_t bus_q, bus_d;
  logic     r_prev_q, w_prev_q;
  logic     wr_acc, rd_acc;
  logic [3:0] wr_hit, rd_hit;

  logic [15:0] ptr_q, ptr_d;
  logic [15:0] in_data_q, in_data_d;
  logic        in_vld_q, in_vld_d;
  logic        in_ovr_q, in_ovr_d;
  logic [15:0] out_word_q, out_word_d;
  logic        out_full_q, out_full_d;
  logic        out_ovr_q, out_ovr_d;
  logic [15:0] stat, rd_src;
  logic [15:0] ram_a_rdata;

  logic [DEPTH-1:0]       pv_q, pv_d;
  logic [DEPTH-1:0][15:0] pd_q, pd_d, sv;
  logic                   p_ram_q, p_ram_d;
  logic [15:0]            dout_q, dout_d;

  always_comb begin
    bus_d = '{cs_n: hpi_cs_n, r_n: hpi_r_n, w_n: hpi_w_n,
              addr: hpi_address, data: hpi_data_in};
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bus_q    <= BUS_IDLE;
      r_prev_q <= 1'b0;
      w_prev_q <= 1'b0;
    end else begin
      bus_q    <= bus_d;
      r_prev_q <= bus_q.r_n;
      w_prev_q <= bus_q.w_n;
    end
  end

  // A write falling together with (or under) a read shadows it
  always_comb begin
    wr_acc = !bus_q.cs_n && w_prev_q && !bus_q.w_n;
    rd_acc = !bus_q.cs_n && r_prev_q && !bus_q.r_n && bus_q.w_n;
    wr_hit = wr_acc ? (4'b0001 << bus_q.addr) : 4'b0000;
    rd_hit = rd_acc ? (4'b0001 << bus_q.addr) : 4'b0000;
  end

  hpi_dpram #(.AW(MEM_AW)) u_ram (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .a_we    (wr_hit[REG_DATA]),
    .a_addr  (ptr_q[MEM_AW:1]),
    .a_wdata (bus_q.data),
    .a_rdata (ram_a_rdata),
    .b_we    (loc_we),
    .b_addr  (loc_addr),
    .b_wdata (loc_wdata),
    .b_rdata (loc_rdata)
  );

  always_comb begin
    ptr_d      = ptr_q;
    in_data_d  = in_data_q;
    in_vld_d   = in_vld_q;
    in_ovr_d   = in_ovr_q;
    out_word_d = out_word_q;
    out_full_d = out_full_q;
    out_ovr_d  = out_ovr_q;
    stat = stat_word(in_vld_q, out_full_q, in_ovr_q, out_ovr_q);

    if (wr_hit[REG_ADDR]) ptr_d = bus_q.data;
    else if (wr_hit[REG_DATA] || rd_hit[REG_DATA])
      ptr_d = ptr_q + 16'd2;

    if (wr_hit[REG_STAT]) begin
      if (bus_q.data[ST_IN_OVR])  in_ovr_d  = 1'b0;
      if (bus_q.data[ST_OUT_OVR]) out_ovr_d = 1'b0;
    end

    if (wr_hit[REG_MBX]) begin
      in_data_d = bus_q.data;
      in_vld_d  = 1'b1;
      if (in_vld_q && !mbx_in_ack) in_ovr_d = 1'b1;
    end else if (mbx_in_ack) begin
      in_vld_d = 1'b0;
    end

    if (mbx_out_wr) begin
      out_word_d = mbx_out_data;
      out_full_d = 1'b1;
      if (out_full_q && !rd_hit[REG_MBX]) out_ovr_d = 1'b1;
    end else if (rd_hit[REG_MBX]) begin
      out_full_d = 1'b0;
    end

    rd_src = '0;
    unique case (bus_q.addr)
      REG_MBX:  rd_src = out_word_q;
      REG_ADDR: rd_src = ptr_q;
      REG_STAT: rd_src = stat;
      default:  rd_src = '0;
    endcase
  end

  // Stage 0 of a DATA read only gets its word once the RAM answers
  always_comb begin
    sv    = pd_q;
    sv[0] = p_ram_q ? ram_a_rdata : pd_q[0];
    pv_d    = '0;
    pd_d    = '0;
    pv_d[0] = rd_acc;
    pd_d[0] = rd_src;
    p_ram_d = rd_hit[REG_DATA];
    for (int i = 1; i < DEPTH; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = sv[i-1];
    end
    dout_d = pv_q[DEPTH-1] ? sv[DEPTH-1] : dout_q;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ptr_q      <= '0;
      in_data_q  <= '0;
      in_vld_q   <= 1'b0;
      in_ovr_q   <= 1'b0;
      out_word_q <= '0;
      out_full_q <= 1'b0;
      out_ovr_q  <= 1'b0;
      pv_q       <= '0;
      pd_q       <= '0;
      p_ram_q    <= 1'b0;
      dout_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      in_data_q  <= in_data_d;
      in_vld_q   <= in_vld_d;
      in_ovr_q   <= in_ovr_d;
      out_word_q <= out_word_d;
      out_full_q <= out_full_d;
      out_ovr_q  <= out_ovr_d;
      pv_q       <= pv_d;
      pd_q       <= pd_d;
      p_ram_q    <= p_ram_d;
      dout_q     <= dout_d;
    end
  end

  assign hpi_data_out = dout_q;
  assign hpi_int      = out_full_q;
  assign mbx_in_data  = in_data_q;
  assign mbx_in_valid = in_vld_q;
  assign mbx_out_full = out_full_q;

endmodule

// File: tb/tb_hpi_target.sv
// Directed + randomized bench for hpi_target against a
// word-level model of the host port and mailboxes.
module tb_hpi_target;

  localparam int AW  = 8;
  localparam int LAT = 2;
  localparam int NW  = 2**AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    addr;
  logic          cs_n, r_n, w_n;
  logic [15:0]   din, dout;
  logic          irq;
  logic [AW-1:0] loc_addr;
  logic          loc_we;
  logic [15:0]   loc_wdata, loc_rdata;
  logic [15:0]   in_data;
  logic          in_valid, in_ack;
  logic [15:0]   out_data;
  logic          out_wr, out_full;

  always #5 clk = ~clk;

  hpi_target #(.MEM_AW(AW), .RD_LAT(LAT)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .hpi_address   (addr),
    .hpi_cs_n      (cs_n),
    .hpi_r_n       (r_n),
    .hpi_w_n       (w_n),
    .hpi_data_in   (din),
    .hpi_data_out  (dout),
    .hpi_int       (irq),
    .loc_addr      (loc_addr),
    .loc_we        (loc_we),
    .loc_wdata     (loc_wdata),
    .loc_rdata     (loc_rdata),
    .mbx_in_data   (in_data),
    .mbx_in_valid  (in_valid),
    .mbx_in_ack    (in_ack),
    .mbx_out_data  (out_data),
    .mbx_out_wr    (out_wr),
    .mbx_out_full  (out_full)
  );

  int vec = 0;
  int bad = 0;

  // Reference model state
  logic [15:0] m_mem [NW];
  bit          m_known [NW];
  logic [15:0] m_ptr, m_in_data, m_out_word, m_last;
  bit          m_in_vld, m_in_ovr, m_out_full, m_out_ovr;

  function automatic int widx(input logic [15:0] p);
    return int'(p >> 1) % NW;
  endfunction

  function automatic logic [15:0] m_stat();
    return {12'd0, m_out_ovr, m_in_ovr, m_out_full, m_in_vld};
  endfunction

  task automatic model_reset();
    m_ptr = '0; m_in_data = '0; m_out_word = '0; m_last = '0;
    m_in_vld = 0; m_in_ovr = 0; m_out_full = 0; m_out_ovr = 0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    cs_n = 0; addr = a; din = d; w_n = 0;
    repeat (3) @(posedge clk); #1;
    w_n = 1; cs_n = 1;
    repeat (2) @(posedge clk);
    case (a)
      2'd0: begin
        m_mem[widx(m_ptr)] = d; m_known[widx(m_ptr)] = 1;
        m_ptr = m_ptr + 16'd2;
      end
      2'd1: begin
        if (m_in_vld) m_in_ovr = 1;
        m_in_data = d; m_in_vld = 1;
      end
      2'd2: m_ptr = d;
      default: begin
        if (d[2]) m_in_ovr = 0;
        if (d[3]) m_out_ovr = 0;
      end
    endcase
  endtask

  task automatic host_rd(input logic [1:0] a, input string tag);
    logic [15:0] exp;
    case (a)
      2'd0: begin exp = m_mem[widx(m_ptr)]; m_ptr = m_ptr + 16'd2; end
      2'd1: begin exp = m_out_word; m_out_full = 0; end
      2'd2: exp = m_ptr;
      default: exp = m_stat();
    endcase
    @(posedge clk); #1;
    cs_n = 0; addr = a; r_n = 0;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    chk({tag, "_early"}, dout, m_last);
    @(posedge clk);
    @(negedge clk);
    chk(tag, dout, exp);
    m_last = exp;
    @(posedge clk); #1;
    r_n = 1; cs_n = 1;
    repeat (2) @(posedge clk);
  endtask

  task automatic loc_wr(input int a, input logic [15:0] d);
    @(posedge clk); #1;
    loc_addr = AW'(a); loc_wdata = d; loc_we = 1;
    @(posedge clk); #1;
    loc_we = 0;
    m_mem[a] = d; m_known[a] = 1;
  endtask

  task automatic loc_rd(input int a, input string tag);
    @(posedge clk); #1;
    loc_addr = AW'(a);
    @(posedge clk);
    @(negedge clk);
    chk(tag, loc_rdata, m_mem[a]);
  endtask

  task automatic out_post(input logic [15:0] d);
    @(posedge clk); #1;
    out_data = d; out_wr = 1;
    @(posedge clk); #1;
    out_wr = 0;
    if (m_out_full) m_out_ovr = 1;
    m_out_word = d; m_out_full = 1;
  endtask

  task automatic ack_pulse();
    @(posedge clk); #1;
    in_ack = 1;
    @(posedge clk); #1;
    in_ack = 0;
    m_in_vld = 0;
  endtask

  task automatic chk_flags(input string tag);
    @(negedge clk);
    chk({tag, "_int"}, 16'(irq), 16'(m_out_full));
    chk({tag, "_ofull"}, 16'(out_full), 16'(m_out_full));
    chk({tag, "_ivld"}, 16'(in_valid), 16'(m_in_vld));
    chk({tag, "_idata"}, in_data, m_in_data);
  endtask

  initial begin
    logic [15:0] d;
    int a;
    rst_n = 0; cs_n = 1; r_n = 1; w_n = 1; addr = 0; din = 0;
    loc_addr = 0; loc_we = 0; loc_wdata = 0;
    in_ack = 0; out_data = 0; out_wr = 0;
    for (int i = 0; i < NW; i++) begin m_mem[i] = 0; m_known[i] = 0; end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    chk("rst_dout", dout, 16'h0);
    chk("rst_lrd", loc_rdata, 16'h0);
    chk_flags("rst");
    host_rd(2'd2, "rst_addr");

    // Sequential DATA writes and readback both ways
    host_wr(2'd2, 16'h0010);
    host_wr(2'd0, 16'h1111);
    host_wr(2'd0, 16'h2222);
    host_rd(2'd2, "addr_after_wr");
    loc_rd(8, "loc8");
    loc_rd(9, "loc9");
    host_wr(2'd2, 16'h0010);
    host_rd(2'd0, "rd_1111");
    host_rd(2'd0, "rd_2222");

    // Word index wrap at top of RAM and 16-bit pointer wrap
    host_wr(2'd2, 16'(2*NW - 2));
    host_wr(2'd0, 16'hAAAA);
    host_wr(2'd0, 16'hBBBB);
    loc_rd(NW-1, "wrap_top");
    loc_rd(0, "wrap_w0");
    host_rd(2'd2, "wrap_addr");
    host_wr(2'd2, 16'hFFFE);
    host_wr(2'd0, 16'hC3C3);
    host_rd(2'd2, "ptr_wrap16");
    loc_rd(NW-1, "ptr_wrap_word");

    // Host->local mailbox with overrun and clear
    host_wr(2'd1, 16'h00A5);
    chk_flags("mbx_in1");
    host_wr(2'd1, 16'h005A);
    host_rd(2'd3, "stat_ovr");
    host_wr(2'd3, 16'h0004);
    host_rd(2'd3, "stat_clr");
    ack_pulse();
    chk_flags("mbx_ack");

    // Local->host mailbox
    out_post(16'hBEEF);
    chk_flags("mbx_out");
    host_rd(2'd1, "mbx_rd");
    chk_flags("mbx_out_rd");
    out_post(16'h1234);
    out_post(16'h5678);
    host_rd(2'd3, "stat_oovr");
    host_wr(2'd3, 16'h0008);
    host_rd(2'd1, "mbx_rd2");
    host_rd(2'd3, "stat_oclr");

    // Read and write together: write wins, no read data
    host_wr(2'd2, 16'h0040);
    @(posedge clk); #1;
    cs_n = 0; addr = 2'd0; din = 16'h1234; r_n = 0; w_n = 0;
    repeat (4) @(posedge clk); #1;
    r_n = 1; w_n = 1; cs_n = 1;
    repeat (3) @(posedge clk);
    m_mem[32] = 16'h1234; m_known[32] = 1; m_ptr = m_ptr + 16'd2;
    @(negedge clk);
    chk("rw_no_rdata", dout, m_last);
    loc_rd(32, "rw_ram");
    host_rd(2'd2, "rw_ptr");

    // Host and local write the same word in the same cycle
    @(posedge clk); #1;
    cs_n = 0; addr = 2'd0; din = 16'h1357; w_n = 0;
    @(posedge clk); #1;
    loc_addr = AW'(widx(m_ptr)); loc_wdata = 16'h2468; loc_we = 1;
    @(posedge clk); #1;
    loc_we = 0;
    @(posedge clk); #1;
    w_n = 1; cs_n = 1;
    repeat (2) @(posedge clk);
    m_mem[widx(m_ptr)] = 16'h1357; m_known[widx(m_ptr)] = 1;
    a = widx(m_ptr);
    m_ptr = m_ptr + 16'd2;
    loc_rd(a, "collide");

    // Reset in the middle of a read
    host_wr(2'd2, 16'h0020);
    @(posedge clk); #1;
    cs_n = 0; addr = 2'd2; r_n = 0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 0;
    #1 cs_n = 1; r_n = 1;
    @(negedge clk);
    chk("rst_rd_dout", dout, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_after", dout, 16'h0);

    // Reset in the middle of a write
    host_wr(2'd2, 16'h0020);
    loc_wr(16, 16'h7777);
    @(posedge clk); #1;
    cs_n = 0; addr = 2'd0; din = 16'h9999; w_n = 0;
    @(posedge clk); #1;
    rst_n = 0;
    #1 cs_n = 1; w_n = 1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    model_reset();
    loc_rd(16, "rst_no_wr");
    host_rd(2'd2, "rst_wr_ptr");

    // Strobe held low through reset release is not an edge
    @(posedge clk); #1;
    rst_n = 0;
    cs_n = 0; addr = 2'd1; din = 16'h4242; w_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    model_reset();
    repeat (4) @(posedge clk);
    chk_flags("low_at_rel");
    @(posedge clk); #1;
    w_n = 1; cs_n = 1;
    repeat (2) @(posedge clk);
    chk_flags("low_at_rel2");

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      d = 16'($urandom);
      case ($urandom_range(0, 9))
        0: host_wr(2'd0, d);
        1: if (m_known[widx(m_ptr)]) host_rd(2'd0, "r_data");
           else host_wr(2'd0, d);
        2: host_wr(2'd2, 16'(($urandom_range(0, 63)) * 2));
        3: loc_wr($urandom_range(0, NW-1), d);
        4: begin
          a = $urandom_range(0, NW-1);
          if (m_known[a]) loc_rd(a, "r_loc");
          else loc_wr(a, d);
        end
        5: host_rd(2'd2, "r_addr");
        6: begin host_wr(2'd1, d); chk_flags("r_mbxin"); end
        7: begin
          out_post(d);
          chk_flags("r_post");
          if ($urandom_range(0, 1) == 1) host_rd(2'd1, "r_mbxrd");
        end
        8: host_rd(2'd3, "r_stat");
        default: begin
          if (d[0]) ack_pulse();
          else host_wr(2'd3, d);
          chk_flags("r_misc");
        end
      endcase
    end
    host_rd(2'd3, "final_stat");

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
